// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state type and time-unit constants
// used by the control block and the minute/second display converters.
package stopwatch_pkg;

  localparam int CNT_W      = 16;
  localparam int CS_PER_SEC = 100;
  localparam int CS_PER_MIN = 6000;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSE,
    LAP,
    FULL
  } sw_state_e;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button pulses in, displayed value and status flags out.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic             start_stop;
  logic             clear;
  logic             lap;
  logic [CNT_W-1:0] bin;
  logic             running;
  logic             lap_active;
  logic             overflow;

  modport master (
    output start_stop, clear, lap,
    input  bin, running, lap_active, overflow
  );

  modport slave (
    input  start_stop, clear, lap,
    output bin, running, lap_active, overflow
  );

endinterface

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Prescaler: one-cycle tick every DIV enabled clocks. Holds its phase
// while en is low; clr forces it back to phase 0.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int          W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Phase counter, wraps at DIV-1, frozen when not enabled.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from
    // pre-edge values, so ordering between always_ff blocks cannot matter.
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Gated by en so a phase parked at DIV-1 during pause never fires.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch time base: 100 Hz tick, centisecond counter, and the
// start/pause/clear/lap state machine driving the displayed value.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned MAX_COUNT = 59999
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned      DIV   = CLK_HZ / TICK_HZ;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  sw_state_e        state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [CNT_W-1:0] lap_reg, lap_n;
  logic [CNT_W-1:0] bin_q;
  logic             tick;
  logic             pre_en;
  logic             pre_clr;
  logic             do_clear;

  // A clear pulse only acts once the watch has left IDLE.
  assign do_clear = bus.clear && (state != IDLE);
  assign pre_en   = (state == RUN) || (state == LAP);
  assign pre_clr  = (state == IDLE) || (state == FULL) || do_clear;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  // State, count, lap snapshot and displayed value registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      lap_reg <= '0;
      bin_q   <= '0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      lap_reg <= lap_n;
      bin_q   <= (state_n == LAP) ? lap_n : count_n;
    end
  end

  // Next-state and counter logic; clear beats start_stop beats lap.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_n = state;
    count_n = count;
    lap_n   = lap_reg;

    if (do_clear) begin
      state_n = IDLE;
      count_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_stop) state_n = RUN;
        end
        RUN, LAP: begin
          // Terminal tick saturates and takes precedence over the buttons.
          if (tick && (count == MAX_C)) begin
            state_n = FULL;
          end else begin
            if (tick) count_n = count + 1'b1;
            if (bus.start_stop) begin
              state_n = PAUSE;
            end else if (bus.lap) begin
              if (state == RUN) begin
                state_n = LAP;
                lap_n   = count;
              end else begin
                state_n = RUN;
              end
            end
          end
        end
        PAUSE: begin
          if (bus.start_stop) state_n = RUN;
        end
        FULL: begin
          state_n = FULL;
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
  end

  assign bus.bin        = bin_q;
  assign bus.running    = (state == RUN) || (state == LAP);
  assign bus.lap_active = (state == LAP);
  assign bus.overflow   = (state == FULL);

endmodule
